// File: rtl/memory_waitstate.sv
// Y86 pipeline memory stage with configurable depth/width and programmable wait-state access latency.
// Optional MEM_BYTE_ADDR_EN: byte addressing with alignment check; default build uses word indices.
module memory_waitstate #(
  parameter int         DATA_W      = 64,
  parameter int         DEPTH       = 4096,
  parameter int         WAIT_CYCLES = 2,
  parameter logic [3:0] STAT_AOK    = 4'h1,
  parameter logic [3:0] STAT_ADR    = 4'h2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic [3:0]        m_stat,
  output logic [3:0]        m_icode,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic              m_stall
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_use_vala;
  logic              w_mem_op;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_word;
  logic              w_misalign;
  logic              w_err;
  logic              w_active;
  logic [IDX_W-1:0]  w_idx;
  logic              w_stall;
  logic              w_complete;
  logic              w_wr_en;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  always_comb begin
    w_is_wr    = 1'b0;
    w_is_rd    = 1'b0;
    w_use_vala = 1'b0;
    case (M_icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: w_is_wr = 1'b1;
      I_MRMOVQ:                  w_is_rd = 1'b1;
      I_RET, I_POPQ: begin
        w_is_rd    = 1'b1;
        w_use_vala = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_mem_op = w_is_wr | w_is_rd;
  assign w_addr   = w_use_vala ? M_valA : M_valE;

`ifdef MEM_BYTE_ADDR_EN
  localparam int OFF_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 0;
  localparam logic [DATA_W-1:0] OFF_MASK = DATA_W'((64'd1 << OFF_W) - 64'd1);
  assign w_word     = w_addr >> OFF_W;
  assign w_misalign = (w_addr & OFF_MASK) != '0;
`else
  assign w_word     = w_addr;
  assign w_misalign = 1'b0;
`endif

  // Non-memory ops carry no address, so they can never flag an error.
  assign w_err    = w_mem_op & (w_misalign | (w_word >= DEPTH_LIM));
  assign w_active = w_mem_op & ~w_err;
  assign w_idx    = w_word[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_active) begin
          if (WAIT_CYCLES > 0) begin
            w_stall     = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_WAIT;
          end else begin
            w_complete  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A flushed or now-faulting op abandons the access without completing.
        if (!w_active) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_en = ~rst & w_complete & w_is_wr & (M_stat == STAT_AOK);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= M_valA;
    end
  end

  assign m_stall = w_stall & ~rst;
  assign m_valM  = (~rst & w_complete & w_is_rd) ? r_mem[w_idx] : '0;
  assign m_stat  = w_err ? STAT_ADR : M_stat;
  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstE  = M_dstE;
  assign m_dstM  = M_dstM;

endmodule

// File: tb/tb_memory_waitstate.sv
// Directed bench for memory_waitstate: a 2-wait-state instance and a zero-wait instance, scoreboarded per cycle.
module tb_memory_waitstate;

`ifdef MEM_BYTE_ADDR_EN
  localparam logic [63:0] S = 64'd8;
`else
  localparam logic [63:0] S = 64'd1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  a_stat_i, a_icode_i, a_dstE_i, a_dstM_i;
  logic [63:0] a_valE_i, a_valA_i;
  logic [3:0]  a_stat_o, a_icode_o, a_dstE_o, a_dstM_o;
  logic [63:0] a_valE_o, a_valM_o;
  logic        a_stall_o;

  logic [3:0]  b_icode_i;
  logic [63:0] b_valE_i, b_valA_i;
  logic [3:0]  b_stat_o, b_icode_o, b_dstE_o, b_dstM_o;
  logic [63:0] b_valE_o, b_valM_o;
  logic        b_stall_o;

  typedef struct packed {
    logic [95:0] tag;
    logic        a_st;
    logic [3:0]  a_stat;
    logic [63:0] a_vm;
    logic        b_st;
    logic [3:0]  b_stat;
    logic [63:0] b_vm;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  memory_waitstate #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .M_stat(a_stat_i), .M_icode(a_icode_i), .M_valE(a_valE_i), .M_valA(a_valA_i),
    .M_dstE(a_dstE_i), .M_dstM(a_dstM_i),
    .m_stat(a_stat_o), .m_icode(a_icode_o), .m_valE(a_valE_o), .m_valM(a_valM_o),
    .m_dstE(a_dstE_o), .m_dstM(a_dstM_o), .m_stall(a_stall_o)
  );

  memory_waitstate #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .M_stat(4'h1), .M_icode(b_icode_i), .M_valE(b_valE_i), .M_valA(b_valA_i),
    .M_dstE(4'h3), .M_dstM(4'h4),
    .m_stat(b_stat_o), .m_icode(b_icode_o), .m_valE(b_valE_o), .m_valM(b_valM_o),
    .m_dstE(b_dstE_o), .m_dstM(b_dstM_o), .m_stall(b_stall_o)
  );

  task automatic drive(input logic [3:0] icode, input logic [63:0] vale,
                       input logic [63:0] vala, input logic [3:0] stat);
    a_icode_i = icode;
    a_valE_i  = vale;
    a_valA_i  = vala;
    a_stat_i  = stat;
    a_dstE_i  = icode ^ 4'h5;
    a_dstM_i  = ~icode;
  endtask

  task automatic chk1(input logic [95:0] tag, input string fld, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %0s.%0s got %0b want %0b", tag, fld, obs, exp);
    end
  endtask

  task automatic chk64(input logic [95:0] tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %0s.%0s got %0h want %0h", tag, fld, obs, exp);
    end
  endtask

  // Push expectation, sample mid-cycle, pop and compare, then advance past the next edge.
  task automatic cyc(input logic [95:0] tag, input logic a_st, input logic [3:0] a_stat,
                     input logic [63:0] a_vm, input logic b_st, input logic [63:0] b_vm);
    exp_t e;
    q_exp.push_back('{tag: tag, a_st: a_st, a_stat: a_stat, a_vm: a_vm,
                      b_st: b_st, b_stat: 4'h1, b_vm: b_vm});
    @(negedge clk);
    e = q_exp.pop_front();
    chk1 (e.tag, "a_stall", a_stall_o, e.a_st);
    chk64(e.tag, "a_stat",  64'(a_stat_o), 64'(e.a_stat));
    chk64(e.tag, "a_valM",  a_valM_o, e.a_vm);
    chk64(e.tag, "a_icode", 64'(a_icode_o), 64'(a_icode_i));
    chk64(e.tag, "a_valE",  a_valE_o, a_valE_i);
    chk64(e.tag, "a_dst",   {56'd0, a_dstE_o, a_dstM_o}, {56'd0, a_icode_i ^ 4'h5, ~a_icode_i});
    chk1 (e.tag, "b_stall", b_stall_o, e.b_st);
    chk64(e.tag, "b_stat",  64'(b_stat_o), 64'(e.b_stat));
    chk64(e.tag, "b_valM",  b_valM_o, e.b_vm);
    @(posedge clk);
    #1;
  endtask

  // A three-cycle access on the 2-wait instance: two stall cycles then completion.
  task automatic acc3(input logic [95:0] tag, input logic [3:0] stat, input logic [63:0] vm);
    cyc(tag, 1'b1, stat, 64'd0, 1'b0, 64'd0);
    cyc(tag, 1'b1, stat, 64'd0, 1'b0, 64'd0);
    cyc(tag, 1'b0, stat, vm,    1'b0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    b_icode_i = 4'h0;
    b_valE_i  = '0;
    b_valA_i  = '0;
    drive(4'h0, 64'd0, 64'd0, 4'h1);

    cyc("rst_idle", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);
    drive(4'h5, 64'd0, 64'd0, 4'h1);
    cyc("rst_read", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);
    rst = 1'b0;

    drive(4'h4, 10 * S, 64'hDEAD, 4'h1);
    acc3("wr10", 4'h1, 64'd0);
    drive(4'h5, 10 * S, 64'd0, 4'h1);
    acc3("rd10", 4'h1, 64'hDEAD);

    drive(4'hB, 64'd0, 4096 * S, 4'h1);
    cyc("popq_err", 1'b0, 4'h2, 64'd0, 1'b0, 64'd0);
    drive(4'h4, 4096 * S, 64'h1234, 4'h1);
    cyc("st_err", 1'b0, 4'h2, 64'd0, 1'b0, 64'd0);
    drive(4'hB, 64'd0, 4095 * S, 4'h1);
    acc3("popq_top", 4'h1, 64'd0);
    drive(4'h6, 64'd5000, 64'd5000, 4'h1);
    cyc("nonmem", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);

    drive(4'hA, 5 * S, 64'd7, 4'h4);
    acc3("exc_wr", 4'h4, 64'd0);
    drive(4'h5, 5 * S, 64'd0, 4'h1);
    acc3("exc_rd", 4'h1, 64'd0);

    drive(4'h4, 3 * S, 64'h33, 4'h1);
    cyc("rstw_a", 1'b1, 4'h1, 64'd0, 1'b0, 64'd0);
    rst = 1'b1;
    cyc("rstw_b", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);
    rst = 1'b0;
    drive(4'h5, 3 * S, 64'd0, 4'h1);
    acc3("rstw_rd", 4'h1, 64'd0);

    drive(4'h4, 20 * S, 64'h55, 4'h1);
    cyc("flush_a", 1'b1, 4'h1, 64'd0, 1'b0, 64'd0);
    drive(4'h0, 20 * S, 64'h55, 4'h1);
    cyc("flush_b", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);
    drive(4'h5, 20 * S, 64'd0, 4'h1);
    acc3("flush_rd", 4'h1, 64'd0);

    drive(4'h0, 64'd0, 64'd0, 4'h1);
    b_icode_i = 4'h8;
    b_valE_i  = 100 * S;
    b_valA_i  = 64'hABC;
    cyc("w0_call", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);
    b_icode_i = 4'h9;
    b_valE_i  = 64'd0;
    b_valA_i  = 100 * S;
    cyc("w0_ret", 1'b0, 4'h1, 64'd0, 1'b0, 64'hABC);
    b_icode_i = 4'h0;
    cyc("w0_idle", 1'b0, 4'h1, 64'd0, 1'b0, 64'd0);

`ifdef MEM_BYTE_ADDR_EN
    drive(4'h5, 64'h13, 64'd0, 4'h1);
    cyc("byte_mis", 1'b0, 4'h2, 64'd0, 1'b0, 64'd0);
    drive(4'h5, 64'h50, 64'd0, 4'h1);
    acc3("byte_w10", 4'h1, 64'hDEAD);
    drive(4'h5, 64'h18, 64'd0, 4'h1);
    acc3("byte_w3", 4'h1, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_waitstate.md
Name: memory_waitstate

Overview:
- Parametrised successor to the pipeline memory stage of the Y86 pipelined processor; sits between the M and W pipeline registers.
- Adds configurable data-memory depth, data width, status codes and a programmable wait-state access latency.
- A stall output tells pipeline control to hold the M register and send a bubble to W while an access is pending.
- Stores are suppressed for instructions already carrying an exception.

Parameters:
- DATA_W, 64, width of valE/valA/valM and of each memory word.
- DEPTH, 4096, number of DATA_W words in data memory; legal address range is [0, DEPTH).
- WAIT_CYCLES, 2, stall cycles inserted per memory access; 0 gives single-cycle access.
- STAT_AOK, 4'h1, status code for normal operation.
- STAT_ADR, 4'h2, status code for an invalid data address.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- M_stat  in  4  status from M register.
- M_icode  in  4  instruction code from M register.
- M_valE  in  DATA_W  ALU result, used as address or passed through.
- M_valA  in  DATA_W  store data, or address for ret/popq.
- M_dstE  in  4  E destination register ID.
- M_dstM  in  4  M destination register ID.
- m_stat  out  4  M_stat, or STAT_ADR on address error.
- m_icode  out  4  pass-through of M_icode.
- m_valE  out  DATA_W  pass-through of M_valE.
- m_valM  out  DATA_W  read data; 0 when no read completes this cycle.
- m_dstE  out  4  pass-through of M_dstE.
- m_dstM  out  4  pass-through of M_dstM.
- m_stall  out  1  1 = access pending; hold M register, bubble W.

Behaviour:
- Operation decode:
  - Writes: icode 4, 8, A.
  - Reads: icode 5, 9, B.
  - All other icodes: no access; m_stall=0; m_valM=0.
- Address selection: icode 9 and B use M_valA; 4, 5, 8 and A use M_valE; non-memory ops have no address and never raise an error.
- Address error (dmem_error): asserted when a memory op's address is >= DEPTH (unsigned). On error:
  - m_stat=STAT_ADR.
  - No write, m_valM=0, m_stall=0 (no wait states).
- Pass-through outputs (m_icode, m_valE, m_dstE, m_dstM, and m_stat when no error) are combinational.
- FSM states IDLE and WAIT; cnt is a down-counter of width clog2(WAIT_CYCLES+1).
- IDLE transitions:
  - If a valid memory op is present, WAIT_CYCLES>0 and no error: m_stall=1, cnt<=WAIT_CYCLES-1, next state WAIT.
  - Otherwise the op completes this cycle.
- WAIT transitions:
  - m_stall=1 while cnt!=0; cnt decrements each edge.
  - When cnt==0, next state IDLE with m_stall=0 on the following cycle.
  - That following cycle is the completion cycle.
- Stall duration: m_stall is high for exactly WAIT_CYCLES consecutive cycles per access.
- Completion cycle is the first cycle the op is present with m_stall=0:
  - Read: m_valM=mem[addr] combinationally.
  - Write: mem[addr]<=M_valA at the closing rising edge, only if M_stat==STAT_AOK.
- During stall cycles: m_valM=0 and no write occurs.
- Back-to-back memory ops: each op incurs its own full wait sequence; the FSM re-enters WAIT from IDLE on the cycle after completion.
- If M_icode becomes a non-memory op while in WAIT (flush), the FSM returns to IDLE next edge and no access occurs.
- Reset (async, any state, including mid-WAIT):
  - state=IDLE, cnt=0, m_stall=0; a pending write is abandoned.
  - Memory contents are not reset; the array is zero-initialised at time zero.
  - Combinational outputs follow inputs during reset, except m_valM=0.

Optional Feature:
- Macro MEM_BYTE_ADDR_EN.
- When defined:
  - Addresses are byte addresses; word index is addr >> log2(DATA_W/8).
  - A nonzero low-order offset, or index >= DEPTH, raises the address error.
- When undefined: addresses are word indices, as in the existing stage.

Test Plan:
- WAIT_CYCLES=2, icode 4, valE=10, valA=0xDEAD, stat=1 -> m_stall high for 2 cycles, mem[10]=0xDEAD after the third edge; then icode 5, valE=10 -> m_valM=0xDEAD in the completion cycle and 0 while stalled.
- icode B, valA=4096 -> m_stat=2, m_stall=0, m_valM=0, memory unchanged.
- icode A, valE=5, valA=7, stat=4 (prior exception) -> stall sequence runs, mem[5] stays 0.
- rst pulsed mid-WAIT of a write to addr 3 -> m_stall drops immediately, mem[3] unchanged; next op starts from IDLE with a full stall.
- WAIT_CYCLES=0, icode 8 then 9 back-to-back at addr 100 -> m_stall never asserted; read returns the value written by the previous cycle's store.
- MEM_BYTE_ADDR_EN defined, icode 5, valE=0x13 -> m_stat=2; valE=0x18 -> reads word 3.
